// File: rtl/captura_operandos.sv
// Operand capture: consumes keypad events one at a time, builds decimal operands A and B,
// and hands both to the arithmetic stage in binary over a valid/ack handshake.
module captura_operandos #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   input  logic [3:0]            key_num,
   input  logic                  key_clear,
   input  logic                  key_save,
   output logic                  key_ack,
   output logic [BIN_W-1:0]      op_a,
   output logic [BIN_W-1:0]      op_b,
   output logic                  ops_valid,
   input  logic                  ops_ack,
   output logic [4*DIGITS-1:0]   entry_bcd,
   output logic [2:0]            entry_cnt,
   output logic [1:0]            phase
);

   localparam int BCD_W = 4 * DIGITS;

   localparam logic [1:0] ST_ENTER_A = 2'd0;
   localparam logic [1:0] ST_ENTER_B = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             ack_q, ack_d;
   logic [BIN_W-1:0] acc_q, acc_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [BIN_W-1:0] op_a_q, op_a_d;
   logic [BIN_W-1:0] op_b_q, op_b_d;
   logic             vld_q, vld_d;

   logic done_ack;
   logic accept;
   logic is_digit;
   logic entry_empty;
   logic entry_full;

   // A consumer ack in DONE takes precedence; the pending key waits one edge.
   assign done_ack    = (state_q == ST_DONE) && ops_ack;
   assign accept      = key_valid && !ack_q && !done_ack;
   assign is_digit    = (key_num <= 4'd9);
   assign entry_empty = (cnt_q == 3'd0);
   assign entry_full  = (cnt_q >= 3'(DIGITS));

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      vld_d   = vld_q;

      if (done_ack) begin
         vld_d   = 1'b0;
         op_a_d  = '0;
         op_b_d  = '0;
         state_d = ST_ENTER_A;
      end else if (accept) begin
         ack_d = 1'b1;
         if (key_clear) begin
            case (state_q)
               ST_ENTER_A: begin
                  acc_d = '0;
                  bcd_d = '0;
                  cnt_d = '0;
               end
               ST_ENTER_B: begin
                  if (!entry_empty) begin
                     acc_d = '0;
                     bcd_d = '0;
                     cnt_d = '0;
                  end else begin
                     op_a_d  = '0;
                     state_d = ST_ENTER_A;
                  end
               end
               ST_DONE: begin
                  op_a_d  = '0;
                  op_b_d  = '0;
                  vld_d   = 1'b0;
                  state_d = ST_ENTER_A;
               end
               default: state_d = ST_ENTER_A;
            endcase
         end else if (key_save) begin
            if (!entry_empty && (state_q == ST_ENTER_A)) begin
               op_a_d  = acc_q;
               acc_d   = '0;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_ENTER_B;
            end else if (!entry_empty && (state_q == ST_ENTER_B)) begin
               op_b_d  = acc_q;
               acc_d   = '0;
               bcd_d   = '0;
               cnt_d   = '0;
               vld_d   = 1'b1;
               state_d = ST_DONE;
            end
         end else if (is_digit && !entry_full && (state_q != ST_DONE)) begin
            acc_d = acc_q * BIN_W'(10) + BIN_W'(key_num);
            bcd_d = (bcd_q << 4) | BCD_W'(key_num);
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ENTER_A;
         ack_q   <= 1'b0;
         acc_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         vld_q   <= vld_d;
      end
   end

   assign key_ack   = ack_q;
   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign ops_valid = vld_q;
   assign entry_bcd = bcd_q;
   assign entry_cnt = cnt_q;
   assign phase     = state_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed scenarios plus random key streams
// checked against a decimal-level model of the operand entry.
module tb_captura_operandos;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              key_valid;
   logic [3:0]        key_num;
   logic              key_clear;
   logic              key_save;
   logic              key_ack;
   logic [BIN_W-1:0]  op_a;
   logic [BIN_W-1:0]  op_b;
   logic              ops_valid;
   logic              ops_ack;
   logic [4*DIGITS-1:0] entry_bcd;
   logic [2:0]        entry_cnt;
   logic [1:0]        phase;

   int vectors    = 0;
   int miscompares = 0;

   captura_operandos #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_num(key_num),
      .key_clear(key_clear), .key_save(key_save), .key_ack(key_ack),
      .op_a(op_a), .op_b(op_b), .ops_valid(ops_valid), .ops_ack(ops_ack),
      .entry_bcd(entry_bcd), .entry_cnt(entry_cnt), .phase(phase)
   );

   always #5 clk = ~clk;

   // Reference model: operands as integers, current entry as a list of decimal digits
   int m_phase;
   int m_dig[$];
   int m_a, m_b;
   bit m_valid;

   function automatic int m_val();
      int v = 0;
      foreach (m_dig[i]) v = v * 10 + m_dig[i];
      return v % (1 << BIN_W);
   endfunction

   function automatic logic [4*DIGITS-1:0] m_bcd();
      logic [4*DIGITS-1:0] b = '0;
      foreach (m_dig[i]) b = (b << 4) | (4*DIGITS)'(m_dig[i]);
      return b;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_dig.delete(); m_a = 0; m_b = 0; m_valid = 0;
   endtask

   task automatic model_key(input int num, input bit clr, input bit sav);
      if (clr) begin
         if (m_phase == 0) m_dig.delete();
         else if (m_phase == 1) begin
            if (m_dig.size() > 0) m_dig.delete();
            else begin m_a = 0; m_phase = 0; end
         end else begin
            m_a = 0; m_b = 0; m_valid = 0; m_phase = 0;
         end
      end else if (sav) begin
         if (m_phase < 2 && m_dig.size() > 0) begin
            if (m_phase == 0) m_a = m_val();
            else begin m_b = m_val(); m_valid = 1; end
            m_dig.delete();
            m_phase++;
         end
      end else if (num <= 9 && m_phase < 2 && m_dig.size() < DIGITS) begin
         m_dig.push_back(num);
      end
   endtask

   task automatic model_opsack();
      if (m_phase == 2) begin m_valid = 0; m_a = 0; m_b = 0; m_phase = 0; end
   endtask

   // Present one event, drop valid once it has been acked; report ack on both edges
   task automatic press(input logic [3:0] num, input logic clr, input logic sav,
                        output logic a1, output logic a2);
      key_num = num; key_clear = clr; key_save = sav; key_valid = 1'b1;
      @(posedge clk); #1;
      a1 = key_ack;
      key_valid = 1'b0; key_clear = 1'b0; key_save = 1'b0;
      model_key(int'(num), clr, sav);
      @(posedge clk); #1;
      a2 = key_ack;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; key_valid = 1'b0; ops_ack = 1'b0;
      key_clear = 1'b0; key_save = 1'b0; key_num = 4'd0;
      model_reset();
      #13; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [BIN_W-1:0] zero_w = '0;
      rst_n = 1'b0; ops_ack = 1'b0; key_clear = 1'b0; key_save = 1'b0;
      key_num = 4'd5; key_valid = 1'b1;
      model_reset();
      #17;
      vectors++;
      if ({key_ack, ops_valid, op_a, op_b, entry_bcd, entry_cnt, phase} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack=%0b vld=%0b a=%0d b=%0d bcd=%h cnt=%0d ph=%0d, want all 0",
                  key_ack, ops_valid, op_a, op_b, entry_bcd, entry_cnt, phase);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (key_ack !== 1'b1) begin
         miscompares++; $display("FAIL reset_first_ack: got %0b want 1", key_ack);
      end
      key_valid = 1'b0;
      model_key(5, 0, 0);
      @(posedge clk); #1;
      vectors++;
      if (key_ack !== 1'b0 || entry_cnt !== 3'(m_dig.size()) || op_a !== zero_w) begin
         miscompares++;
         $display("FAIL reset_ack_pulse: got ack=%0b cnt=%0d a=%0d want 0/%0d/0", key_ack, entry_cnt, op_a, m_dig.size());
      end
   endtask

   task automatic test_hold_valid();
      int acks = 0;
      do_reset();
      key_num = 4'd7; key_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (key_ack) acks++;
         if (i == 1) key_valid = 1'b0;
      end
      model_key(7, 0, 0);
      vectors++;
      if (acks !== 1) begin
         miscompares++; $display("FAIL hold_single_ack: got %0d acks want 1", acks);
      end
      vectors++;
      if (entry_bcd !== m_bcd() || entry_cnt !== 3'd1) begin
         miscompares++;
         $display("FAIL hold_entry: got bcd=%h cnt=%0d want %h/1", entry_bcd, entry_cnt, m_bcd());
      end
   endtask

   task automatic test_overflow();
      logic a1, a2;
      int nack = 0;
      do_reset();
      for (int d = 1; d <= 4; d++) begin
         press(4'(d), 1'b0, 1'b0, a1, a2);
         if (a1 === 1'b1 && a2 === 1'b0) nack++;
      end
      vectors++;
      if (nack !== 4) begin
         miscompares++; $display("FAIL overflow_acks: got %0d clean acks want 4", nack);
      end
      vectors++;
      if (entry_bcd !== 12'h123 || entry_cnt !== 3'd3) begin
         miscompares++; $display("FAIL overflow_entry: got bcd=%h cnt=%0d want 123/3", entry_bcd, entry_cnt);
      end
      press(4'd0, 1'b0, 1'b1, a1, a2);
      vectors++;
      if (op_a !== 10'd123 || phase !== 2'd1 || entry_cnt !== 3'd0) begin
         miscompares++; $display("FAIL overflow_save: got a=%0d ph=%0d cnt=%0d want 123/1/0", op_a, phase, entry_cnt);
      end
   endtask

   task automatic test_full_flow();
      logic a1, a2;
      do_reset();
      press(4'd4, 0, 0, a1, a2); press(4'd5, 0, 0, a1, a2); press(4'd0, 0, 1, a1, a2);
      press(4'd9, 0, 0, a1, a2); press(4'd0, 0, 1, a1, a2);
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (phase !== 2'd2 || op_a !== 10'd45 || op_b !== 10'd9 || ops_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL flow_done: got ph=%0d a=%0d b=%0d vld=%0b want 2/45/9/1", phase, op_a, op_b, ops_valid);
      end
      press(4'd3, 0, 0, a1, a2);
      vectors++;
      if (entry_cnt !== 3'd0 || op_a !== 10'd45 || ops_valid !== 1'b1 || a1 !== 1'b1) begin
         miscompares++;
         $display("FAIL flow_done_digit: got cnt=%0d a=%0d vld=%0b ack=%0b want 0/45/1/1", entry_cnt, op_a, ops_valid, a1);
      end
      ops_ack = 1'b1;
      @(posedge clk); #1;
      ops_ack = 1'b0;
      model_opsack();
      vectors++;
      if (ops_valid !== 1'b0 || phase !== 2'd0 || op_a !== 10'd0 || op_b !== 10'd0) begin
         miscompares++;
         $display("FAIL flow_ops_ack: got vld=%0b ph=%0d a=%0d b=%0d want 0/0/0/0", ops_valid, phase, op_a, op_b);
      end
   endtask

   task automatic test_clear_priority();
      logic a1, a2;
      do_reset();
      press(4'd5, 0, 0, a1, a2); press(4'd6, 0, 0, a1, a2);
      press(4'd0, 1, 1, a1, a2);
      vectors++;
      if (entry_cnt !== 3'd0 || entry_bcd !== 12'h000 || phase !== 2'd0 || op_a !== 10'd0) begin
         miscompares++;
         $display("FAIL clear_priority: got cnt=%0d bcd=%h ph=%0d a=%0d want 0/000/0/0", entry_cnt, entry_bcd, phase, op_a);
      end
      press(4'd0, 0, 1, a1, a2);
      vectors++;
      if (a1 !== 1'b1 || phase !== 2'd0 || op_a !== 10'd0 || entry_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL empty_save: got ack=%0b ph=%0d a=%0d cnt=%0d want 1/0/0/0", a1, phase, op_a, entry_cnt);
      end
   endtask

   task automatic test_done_collision();
      logic a1, a2;
      do_reset();
      press(4'd2, 0, 0, a1, a2); press(4'd0, 0, 1, a1, a2);
      press(4'd8, 0, 0, a1, a2); press(4'd0, 0, 1, a1, a2);
      key_num = 4'd3; key_valid = 1'b1; ops_ack = 1'b1;
      @(posedge clk); #1;
      ops_ack = 1'b0;
      model_opsack();
      vectors++;
      if (key_ack !== 1'b0 || phase !== 2'd0 || ops_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL collision_no_ack: got ack=%0b ph=%0d vld=%0b want 0/0/0", key_ack, phase, ops_valid);
      end
      @(posedge clk); #1;
      key_valid = 1'b0;
      model_key(3, 0, 0);
      vectors++;
      if (key_ack !== 1'b1 || entry_cnt !== 3'd1 || entry_bcd !== 12'h003) begin
         miscompares++;
         $display("FAIL collision_late_ack: got ack=%0b cnt=%0d bcd=%h want 1/1/003", key_ack, entry_cnt, entry_bcd);
      end
      @(posedge clk); #1;
      // Separately: clear with empty B entry steps back to A and drops op_a
      do_reset();
      press(4'd8, 0, 0, a1, a2); press(4'd0, 0, 1, a1, a2);
      press(4'd0, 1, 0, a1, a2);
      vectors++;
      if (phase !== 2'd0 || op_a !== 10'd0) begin
         miscompares++; $display("FAIL clear_b_empty: got ph=%0d a=%0d want 0/0", phase, op_a);
      end
   endtask

   task automatic test_random();
      logic a1, a2;
      logic [3:0] num;
      logic clr, sav;
      do_reset();
      for (int n = 0; n < 250; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
            ops_ack = 1'b1;
            @(posedge clk); #1;
            ops_ack = 1'b0;
            model_opsack();
         end
         num = 4'($urandom_range(0, 15));
         clr = ($urandom_range(0, 11) == 0);
         sav = ($urandom_range(0, 4) == 0);
         press(num, clr, sav, a1, a2);
         vectors++;
         if (a1 !== 1'b1 || a2 !== 1'b0) begin
            miscompares++; $display("FAIL rnd_ack[%0d]: got %0b%0b want 10", n, a1, a2);
         end
         vectors++;
         if (phase !== 2'(m_phase) || ops_valid !== m_valid ||
             op_a !== BIN_W'(m_a) || op_b !== BIN_W'(m_b)) begin
            miscompares++;
            $display("FAIL rnd_ops[%0d]: got ph=%0d vld=%0b a=%0d b=%0d want %0d/%0b/%0d/%0d",
                     n, phase, ops_valid, op_a, op_b, m_phase, m_valid, m_a, m_b);
         end
         vectors++;
         if (entry_cnt !== 3'(m_dig.size()) || entry_bcd !== m_bcd()) begin
            miscompares++;
            $display("FAIL rnd_entry[%0d]: got cnt=%0d bcd=%h want %0d/%h",
                     n, entry_cnt, entry_bcd, m_dig.size(), m_bcd());
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold_valid();
      test_overflow();
      test_full_flow();
      test_clear_priority();
      test_done_collision();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
